sram_responder: RTL and testbench

- Synthesizable behavioural model of the 64-bit external SRAM. It is the device end of the SRAM_DQ / SRAM_ADDR / SRAM_WE_N bus.
- The memory-stage SRAM controller drives that bus as initiator. This block responds to it.
- Used in simulation and on-FPGA bring-up in place of the physical SRAM.
- Stores 64-bit words. Returns read data with programmable latency, releases DQ during writes and bus turnaround, and exposes debug counters/flags for the bench.

---
 rtl/sram_responder.sv | 112 +++++++++++
 tb/tb_sram_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: behavioural 64-bit SRAM device model for the SRAM_DQ/ADDR/WE_N bus.
// Ports: clk, rst, SRAM_ADDR, SRAM_WE_N, SRAM_DQ (inout), dq_drive, write_count, oor_seen.
module sram_responder #(
  parameter int ADDR_W       = 17,
  parameter int MEM_DEPTH    = 65536,
  parameter int READ_LATENCY = 1,
  parameter int TURNAROUND   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  inout  wire  [63:0]       SRAM_DQ,
  output logic              dq_drive,
  output logic [15:0]       write_count,
  output logic              oor_seen
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] TA = 2'(TURNAROUND);

  // Zeroed at time 0 only; rst never clears the array.
  logic [63:0] mem [MEM_DEPTH] = '{default: '0};

  logic [63:0] pipe_q [READ_LATENCY];
  logic [63:0] pipe_d [READ_LATENCY];
  logic [1:0]  hiz_q, hiz_d;
  logic [15:0] wc_q, wc_d;
  logic        oor_q, oor_d;

  logic             wr;
  logic             rd;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_out;

  // An unknown WE_N falls through both tests: neither read nor write.
  always_comb begin
    wr = 1'b0;
    rd = 1'b0;
    if (SRAM_WE_N == 1'b0) begin
      wr = 1'b1;
    end else if (SRAM_WE_N == 1'b1) begin
      rd = 1'b1;
    end
  end

  assign in_range = 32'(SRAM_ADDR) < 32'(MEM_DEPTH);
  assign idx      = SRAM_ADDR[IDX_W-1:0];

  always_comb begin
    pipe_d[0] = in_range ? mem[idx] : 64'h0;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_comb begin
    hiz_d = hiz_q;
    if (wr) begin
      hiz_d = TA;
    end else if (rd && hiz_q != 2'd0) begin
      hiz_d = hiz_q - 2'd1;
    end
  end

  always_comb begin
    wc_d = wc_q;
    if (wr && in_range && wc_q != 16'hFFFF) begin
      wc_d = wc_q + 16'd1;
    end
  end

  always_comb begin
    oor_d = oor_q;
    if ((wr || rd) && !in_range) begin
      oor_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k] <= 64'h0;
      end
      hiz_q <= TA;
      wc_q  <= 16'h0;
      oor_q <= 1'b0;
    end else begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
      hiz_q <= hiz_d;
      wc_q  <= wc_d;
      oor_q <= oor_d;
    end
  end

  // Array write kept separate so the memory itself has no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr && in_range) begin
      mem[idx] <= SRAM_DQ;
    end
  end

  assign rd_out      = pipe_q[READ_LATENCY-1];
  assign dq_drive    = rd && (hiz_q == 2'd0) && !rst;
  assign SRAM_DQ     = dq_drive ? rd_out : 64'bz;
  assign write_count = wc_q;
  assign oor_seen    = oor_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed scoreboard bench for sram_responder.
// Two instances (read latency 1 and 3) share one stimulus stream.
module tb_sram_responder;

  localparam int K_DQ  = 0;
  localparam int K_WC  = 1;
  localparam int K_OOR = 2;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    logic        drv;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [16:0] addr = '0;
  logic [63:0] wdata = '0;

  wire  [63:0] dq0, dq1;
  logic        drv0, drv1;
  logic [15:0] wc0, wc1;
  logic        oor0, oor1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dq0 = tb_drv ? wdata : 64'bz;
  assign dq1 = tb_drv ? wdata : 64'bz;

  sram_responder #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
    .SRAM_DQ(dq0), .dq_drive(drv0), .write_count(wc0), .oor_seen(oor0)
  );

  sram_responder #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
    .SRAM_DQ(dq1), .dq_drive(drv1), .write_count(wc1), .oor_seen(oor1)
  );

  // dmask bit0 = latency-1 instance, bit1 = latency-3 instance
  task automatic ex(input int off, input int dmask, input int kind,
                    input logic drv, input logic [63:0] val, input string nm);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (dmask[d]) begin
        e.cyc  = cyc + off;
        e.dut  = d;
        e.kind = kind;
        e.drv  = drv;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
      end
    end
  endtask

  task automatic step(input logic r, input logic wn, input logic [16:0] a,
                      input logic [63:0] d);
    rst    = r;
    we_n   = wn;
    addr   = a;
    wdata  = d;
    tb_drv = !wn;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      exp_t        e;
      logic        a_drv;
      logic [63:0] a_dq;
      logic [15:0] a_wc;
      logic        a_oor;
      e     = sb[i];
      a_drv = (e.dut == 0) ? drv0 : drv1;
      a_dq  = (e.dut == 0) ? dq0  : dq1;
      a_wc  = (e.dut == 0) ? wc0  : wc1;
      a_oor = (e.dut == 0) ? oor0 : oor1;
      if (e.cyc == cyc) begin
        checks++;
        if (e.kind == K_DQ) begin
          if (a_drv !== e.drv || (e.drv && a_dq !== e.val)) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: drive=%0b dq=%h want drive=%0b dq=%h",
                     e.name, e.dut, cyc, a_drv, a_dq, e.drv, e.val);
          end
        end else if (e.kind == K_WC) begin
          if (a_wc !== e.val[15:0]) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: write_count=%h want %h",
                     e.name, e.dut, cyc, a_wc, e.val[15:0]);
          end
        end else begin
          if (a_oor !== e.val[0]) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: oor_seen=%0b want %0b",
                     e.name, e.dut, cyc, a_oor, e.val[0]);
          end
        end
        sb.delete(i);
      end else if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: missed at cyc %0d now %0d",
                 e.name, e.dut, e.cyc, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    step(1'b1, 1'b1, 17'h0, 64'h0);
    step(1'b1, 1'b1, 17'h0, 64'h0);

    ex(0, 3, K_DQ, 1'b0, 64'h0, "rst_hiz");
    ex(0, 3, K_WC, 1'b0, 64'h0, "rst_wc");
    ex(0, 3, K_OOR, 1'b0, 64'h0, "rst_oor");
    step(1'b0, 1'b1, 17'h0, 64'h0);
    ex(0, 3, K_DQ, 1'b1, 64'h0, "idle_drive");
    step(1'b0, 1'b1, 17'h0, 64'h0);

    ex(0, 3, K_DQ, 1'b0, 64'h0, "wr_hiz");
    step(1'b0, 1'b0, 17'h10, 64'hDEADBEEF_01234567);
    ex(0, 3, K_DQ, 1'b0, 64'h0, "turn_hiz");
    ex(0, 3, K_WC, 1'b0, 64'd1, "wc1");
    ex(1, 1, K_DQ, 1'b1, 64'hDEADBEEF_01234567, "rd_l1");
    ex(3, 2, K_DQ, 1'b1, 64'hDEADBEEF_01234567, "rd_l3");
    step(1'b0, 1'b1, 17'h10, 64'h0);
    repeat (3) step(1'b0, 1'b1, 17'h10, 64'h0);

    ex(0, 3, K_DQ, 1'b0, 64'h0, "rbw_hiz");
    ex(1, 3, K_WC, 1'b0, 64'd2, "wc2");
    ex(1, 1, K_DQ, 1'b0, 64'h0, "rbw_turn");
    ex(2, 1, K_DQ, 1'b1, 64'h5, "rbw_l1_new");
    ex(3, 2, K_DQ, 1'b1, 64'h0, "rbw_l3_old");
    ex(4, 2, K_DQ, 1'b1, 64'h5, "rbw_l3_new");
    step(1'b0, 1'b0, 17'h20, 64'h5);
    repeat (4) step(1'b0, 1'b1, 17'h20, 64'h0);

    for (int i = 0; i < 4; i++) begin
      ex(0, 3, K_DQ, 1'b0, 64'h0, "b2b_hiz");
      step(1'b0, 1'b0, 17'(i), 64'(i + 1));
    end
    ex(0, 3, K_DQ, 1'b0, 64'h0, "b2b_turn");
    ex(0, 3, K_WC, 1'b0, 64'd6, "wc6");
    for (int i = 0; i < 4; i++) begin
      ex(1, 1, K_DQ, 1'b1, 64'(i + 1), "b2b_l1");
      ex(3, 2, K_DQ, 1'b1, 64'(i + 1), "b2b_l3");
      step(1'b0, 1'b1, 17'(i), 64'h0);
    end
    repeat (3) step(1'b0, 1'b1, 17'h3, 64'h0);

    ex(0, 3, K_DQ, 1'b0, 64'h0, "oor_wr_hiz");
    step(1'b0, 1'b0, 17'h10000, 64'hFF);
    ex(0, 3, K_OOR, 1'b0, 64'h1, "oor_set");
    ex(0, 3, K_WC, 1'b0, 64'd6, "oor_wc");
    ex(1, 1, K_DQ, 1'b1, 64'h0, "oor_rd_l1");
    ex(3, 2, K_DQ, 1'b1, 64'h0, "oor_rd_l3");
    step(1'b0, 1'b1, 17'h10000, 64'h0);
    step(1'b0, 1'b1, 17'h10000, 64'h0);
    ex(1, 1, K_DQ, 1'b1, 64'h1, "oor_mem0_l1");
    ex(3, 2, K_DQ, 1'b1, 64'h1, "oor_mem0_l3");
    step(1'b0, 1'b1, 17'h0, 64'h0);
    repeat (2) step(1'b0, 1'b1, 17'h0, 64'h0);
    ex(0, 3, K_OOR, 1'b0, 64'h1, "oor_sticky");
    step(1'b0, 1'b1, 17'h0, 64'h0);

    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 1'b0, 17'(i & 32'hFFFF), 64'(i));
    end
    ex(0, 3, K_WC, 1'b0, 64'hFFFF, "wc_sat");
    ex(0, 3, K_DQ, 1'b0, 64'h0, "sat_turn");
    step(1'b0, 1'b1, 17'd5, 64'h0);
    ex(0, 1, K_DQ, 1'b1, 64'd5, "pre_rst_l1");
    step(1'b0, 1'b1, 17'd6, 64'h0);
    ex(0, 3, K_DQ, 1'b0, 64'h0, "rst_hiz2");
    step(1'b1, 1'b0, 17'd7, 64'hBAD);
    ex(0, 3, K_DQ, 1'b0, 64'h0, "post_rst_hiz");
    ex(0, 3, K_WC, 1'b0, 64'h0, "post_rst_wc");
    ex(0, 3, K_OOR, 1'b0, 64'h0, "post_rst_oor");
    ex(1, 1, K_DQ, 1'b1, 64'd8, "ret8_l1");
    ex(1, 2, K_DQ, 1'b1, 64'h0, "flush0_l3");
    ex(2, 2, K_DQ, 1'b1, 64'h0, "flush1_l3");
    ex(3, 2, K_DQ, 1'b1, 64'd8, "ret8_l3");
    step(1'b0, 1'b1, 17'd8, 64'h0);
    ex(1, 1, K_DQ, 1'b1, 64'd7, "rst_wr_ign_l1");
    ex(3, 2, K_DQ, 1'b1, 64'd7, "rst_wr_ign_l3");
    step(1'b0, 1'b1, 17'd7, 64'h0);
    ex(1, 1, K_DQ, 1'b1, 64'd65536, "ret0_l1");
    ex(3, 2, K_DQ, 1'b1, 64'd65536, "ret0_l3");
    step(1'b0, 1'b1, 17'd0, 64'h0);
    repeat (5) step(1'b0, 1'b1, 17'd0, 64'h0);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s dut%0d: never compared (due cyc %0d)",
               e.name, e.dut, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
